// File: rtl/dht11_response_formatter.sv
// DHT11 response formatter: latches sensor words, decodes host commands and streams 2-byte replies.
// Optional DHT_FMT_DECIMAL_EN appends the decimal byte to humidity/temperature replies.
module dht11_response_formatter #(
  parameter int unsigned STALE_CYCLES = 100_000_000,
  parameter int unsigned CNT_W        = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sensor_data,
  input  logic        sensor_valid,
  input  logic        sensor_error,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_byte,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        monitor_active
);

  localparam logic [CNT_W-1:0] STALE_MAX = CNT_W'(STALE_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    VAL  = 2'd2
`ifdef DHT_FMT_DECIMAL_EN
    , DEC = 2'd3
`endif
  } state_t;

  state_t           state_reg;
  logic [31:0]      data_reg;
  logic             have_data_reg;
  logic             err_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             mon_on_reg;
  logic             mon_temp_reg;
  logic             pending_reg;
  logic             tx_valid_reg;
  logic [7:0]       tx_byte_reg;
  logic             busy_reg;
  logic [7:0]       val_reg;
  logic             stale;
  logic             ok;
  logic             mon_off_now;
  logic [7:0]       resp_hdr;
  logic [7:0]       resp_val;
`ifdef DHT_FMT_DECIMAL_EN
  logic [7:0]       resp_dec;
  logic             resp_long;
  logic [7:0]       dec_reg;
  logic             long_reg;
`else
  logic             unused_dec;
  assign unused_dec = ^{data_reg[23:16], data_reg[7:0]};
`endif

  assign stale          = (cnt_reg == STALE_MAX);
  assign ok             = have_data_reg & ~err_reg & ~stale;
  assign mon_off_now    = (state_reg == IDLE) && cmd_valid && (cmd_byte == 8'h05);
  assign tx_valid       = tx_valid_reg;
  assign tx_byte        = tx_byte_reg;
  assign busy           = busy_reg;
  assign monitor_active = mon_on_reg;

  // Sensor latch, error flag and saturating staleness counter; a good reading beats a same-cycle error.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg      <= '0;
      have_data_reg <= 1'b0;
      err_reg       <= 1'b0;
      cnt_reg       <= '0;
    end else if (sensor_valid) begin
      data_reg      <= sensor_data;
      have_data_reg <= 1'b1;
      err_reg       <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      if (sensor_error)
        err_reg <= 1'b1;
      if (cnt_reg != STALE_MAX)
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Reply for whatever leaves IDLE this cycle: a command if present, otherwise the monitor push.
  always_comb begin
    resp_hdr = 8'h00;
    resp_val = 8'h00;
`ifdef DHT_FMT_DECIMAL_EN
    resp_dec  = 8'h00;
    resp_long = 1'b0;
`endif
    if (cmd_valid) begin
      case (cmd_byte)
        8'h00: begin
          resp_hdr = 8'h07;
          resp_val = {5'b0, stale, err_reg, have_data_reg};
        end
        8'h01: begin
          if (ok) begin
            resp_hdr = 8'h09;
            resp_val = data_reg[31:24];
`ifdef DHT_FMT_DECIMAL_EN
            resp_dec  = data_reg[23:16];
            resp_long = 1'b1;
`endif
          end else begin
            resp_hdr = 8'h1F;
            resp_val = 8'h01;
          end
        end
        8'h02: begin
          if (ok) begin
            resp_hdr = 8'h0A;
            resp_val = data_reg[15:8];
`ifdef DHT_FMT_DECIMAL_EN
            resp_dec  = data_reg[7:0];
            resp_long = 1'b1;
`endif
          end else begin
            resp_hdr = 8'h1F;
            resp_val = 8'h02;
          end
        end
        8'h03:   resp_hdr = 8'h0B;
        8'h04:   resp_hdr = 8'h0C;
        8'h05:   resp_hdr = 8'h0F;
        default: begin
          resp_hdr = 8'hFF;
          resp_val = cmd_byte;
        end
      endcase
    end else if (mon_temp_reg) begin
      resp_hdr = 8'h0E;
      resp_val = data_reg[15:8];
`ifdef DHT_FMT_DECIMAL_EN
      resp_dec  = data_reg[7:0];
      resp_long = 1'b1;
`endif
    end else begin
      resp_hdr = 8'h0D;
      resp_val = data_reg[31:24];
`ifdef DHT_FMT_DECIMAL_EN
      resp_dec  = data_reg[23:16];
      resp_long = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      tx_valid_reg <= 1'b0;
      tx_byte_reg  <= 8'h00;
      busy_reg     <= 1'b0;
      val_reg      <= 8'h00;
      mon_on_reg   <= 1'b0;
      mon_temp_reg <= 1'b0;
      pending_reg  <= 1'b0;
`ifdef DHT_FMT_DECIMAL_EN
      dec_reg  <= 8'h00;
      long_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid || pending_reg) begin
            state_reg    <= HDR;
            tx_valid_reg <= 1'b1;
            tx_byte_reg  <= resp_hdr;
            busy_reg     <= 1'b1;
            val_reg      <= resp_val;
`ifdef DHT_FMT_DECIMAL_EN
            dec_reg  <= resp_dec;
            long_reg <= resp_long;
`endif
          end
          if (cmd_valid) begin
            case (cmd_byte)
              8'h03: begin
                mon_on_reg   <= 1'b1;
                mon_temp_reg <= 1'b0;
              end
              8'h04: begin
                mon_on_reg   <= 1'b1;
                mon_temp_reg <= 1'b1;
              end
              8'h05: begin
                mon_on_reg  <= 1'b0;
                pending_reg <= 1'b0;
              end
              default: ;
            endcase
          end else if (pending_reg) begin
            pending_reg <= 1'b0;
          end
        end
        HDR: begin
          if (tx_ready) begin
            state_reg   <= VAL;
            tx_byte_reg <= val_reg;
          end
        end
        VAL: begin
          if (tx_ready) begin
`ifdef DHT_FMT_DECIMAL_EN
            if (long_reg) begin
              state_reg   <= DEC;
              tx_byte_reg <= dec_reg;
            end else begin
              state_reg    <= IDLE;
              tx_valid_reg <= 1'b0;
              busy_reg     <= 1'b0;
            end
`else
            state_reg    <= IDLE;
            tx_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
`endif
          end
        end
`ifdef DHT_FMT_DECIMAL_EN
        DEC: begin
          if (tx_ready) begin
            state_reg    <= IDLE;
            tx_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
          end
        end
`endif
        default: begin
          state_reg    <= IDLE;
          tx_valid_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
      // A reading that lands while a push is being launched re-arms pending so it is not lost.
      if (sensor_valid && mon_on_reg && !mon_off_now)
        pending_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dht11_response_formatter.sv
// Directed bench for dht11_response_formatter with hand-computed reply bytes.
// Build with DHT_FMT_DECIMAL_EN to also check the decimal third byte.
module tb_dht11_response_formatter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sensor_data = '0;
  logic        sensor_valid = 1'b0;
  logic        sensor_error = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_byte = '0;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        busy;
  logic        monitor_active;

  int n_checks = 0;
  int n_fail   = 0;

  dht11_response_formatter #(.STALE_CYCLES(1000), .CNT_W(10)) dut (
    .clk(clk), .rst(rst),
    .sensor_data(sensor_data), .sensor_valid(sensor_valid), .sensor_error(sensor_error),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .busy(busy), .monitor_active(monitor_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cmd(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic sensor(input logic [31:0] d, input bit v, input bit e);
    sensor_data  = d;
    sensor_valid = v;
    sensor_error = e;
    step();
    sensor_valid = 1'b0;
    sensor_error = 1'b0;
  endtask

  // Waits (bounded) for a presented byte, checks it, then lets the handshake edge pass.
  task automatic expect_byte(input string tag, input logic [7:0] exp);
    int t = 0;
    while (!tx_valid && t < 100) begin
      step();
      t++;
    end
    check({tag, " valid"}, {31'b0, tx_valid}, 32'd1);
    check(tag, {24'b0, tx_byte}, {24'b0, exp});
    step();
  endtask

  task automatic finish_reply(input string tag, input logic [7:0] hdr, input logic [7:0] val,
                              input bit has_dec, input logic [7:0] dec);
    expect_byte({tag, " hdr"}, hdr);
    expect_byte({tag, " val"}, val);
`ifdef DHT_FMT_DECIMAL_EN
    if (has_dec) expect_byte({tag, " dec"}, dec);
`endif
    check({tag, " idle"}, {31'b0, busy}, 32'd0);
    $display("%s: reply %02h %02h (three-byte=%0d dec %02h)", tag, hdr, val, has_dec, dec);
  endtask

  task automatic cmd_resp(input string tag, input logic [7:0] cmd, input logic [7:0] hdr,
                          input logic [7:0] val, input bit has_dec, input logic [7:0] dec);
    pulse_cmd(cmd);
    check({tag, " lat"}, {31'b0, tx_valid}, 32'd1);
    check({tag, " busy"}, {31'b0, busy}, 32'd1);
    finish_reply(tag, hdr, val, has_dec, dec);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    // 1: reset state, replies with no data
    repeat (3) step();
    check("rst tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst tx_byte", {24'b0, tx_byte}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst monitor", {31'b0, monitor_active}, 32'd0);
    rst = 1'b0;
    step();
    cmd_resp("t1 hum nodata", 8'h01, 8'h1F, 8'h01, 0, 8'h00);
    cmd_resp("t1 status", 8'h00, 8'h07, 8'h00, 0, 8'h00);

    // 2: temperature reply with a 5-cycle stall on the header
    sensor(32'h3C00_1900, 1, 0);
    tx_ready = 1'b0;
    pulse_cmd(8'h02);
    for (int i = 0; i < 5; i++) begin
      check("t2 stall valid", {31'b0, tx_valid}, 32'd1);
      check("t2 stall byte", {24'b0, tx_byte}, 32'h0A);
      step();
    end
    tx_ready = 1'b1;
    finish_reply("t2 temp", 8'h0A, 8'h19, 1, 8'h00);

    // 3: staleness, error flag, valid-beats-error
    sensor(32'h3C00_1900, 1, 0);
    repeat (1001) step();
    cmd_resp("t3 status stale", 8'h00, 8'h07, 8'h05, 0, 8'h00);
    cmd_resp("t3 hum stale", 8'h01, 8'h1F, 8'h01, 0, 8'h00);
    sensor(32'h3C00_1900, 1, 0);
    sensor(32'h0, 0, 1);
    cmd_resp("t3 status err", 8'h00, 8'h07, 8'h03, 0, 8'h00);
    cmd_resp("t3 hum err", 8'h01, 8'h1F, 8'h01, 0, 8'h00);
    sensor(32'h3C05_1900, 1, 1);
    cmd_resp("t3 status both", 8'h00, 8'h07, 8'h01, 0, 8'h00);
    cmd_resp("t3 hum ok", 8'h01, 8'h09, 8'h3C, 1, 8'h05);

    // 4: humidity and temperature monitor pushes
    cmd_resp("t4 mon hum", 8'h03, 8'h0B, 8'h00, 0, 8'h00);
    check("t4 monitor on", {31'b0, monitor_active}, 32'd1);
    sensor(32'h2D00_1700, 1, 0);
    finish_reply("t4 push hum", 8'h0D, 8'h2D, 1, 8'h00);
    cmd_resp("t4 mon temp", 8'h04, 8'h0C, 8'h00, 0, 8'h00);
    sensor(32'h2D00_1742, 1, 0);
    finish_reply("t4 push temp", 8'h0E, 8'h17, 1, 8'h42);
    cmd_resp("t4 mon off", 8'h05, 8'h0F, 8'h00, 0, 8'h00);
    check("t4 monitor off", {31'b0, monitor_active}, 32'd0);

    // 5: pulses and a command while stalled collapse into one push with the latest data
    cmd_resp("t5 mon hum", 8'h03, 8'h0B, 8'h00, 0, 8'h00);
    tx_ready = 1'b0;
    pulse_cmd(8'h00);
    sensor(32'h2000_1100, 1, 0);
    step();
    sensor(32'h2100_1200, 1, 0);
    pulse_cmd(8'h01);
    check("t5 stalled byte", {24'b0, tx_byte}, 32'h07);
    tx_ready = 1'b1;
    finish_reply("t5 status", 8'h07, 8'h01, 0, 8'h00);
    finish_reply("t5 push", 8'h0D, 8'h21, 1, 8'h00);
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid) quiet++;
      step();
    end
    check("t5 no extra", quiet, 0);

    // 6: reset while the header is stalled
    tx_ready = 1'b0;
    pulse_cmd(8'h00);
    check("t6 stalled", {31'b0, tx_valid}, 32'd1);
    rst = 1'b1;
    step();
    check("t6 rst tx_valid", {31'b0, tx_valid}, 32'd0);
    check("t6 rst busy", {31'b0, busy}, 32'd0);
    check("t6 rst monitor", {31'b0, monitor_active}, 32'd0);
    rst = 1'b0;
    tx_ready = 1'b1;
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      if (tx_valid) quiet++;
      step();
    end
    check("t6 no partial", quiet, 0);
    cmd_resp("t6 unknown", 8'h77, 8'hFF, 8'h77, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
